// File: rtl/serial_word_shifter.sv
// Parallel-to-serial word shifter: accepts a WIDTH-bit word and streams it MSB first,
// with per-bit valid, last-bit marker, a done pulse, back-to-back loading and flush.
module serial_word_shifter #(
   parameter int unsigned WIDTH      = 8,
   parameter logic        IDLE_LEVEL = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             flush,
   output logic             x_out,
   output logic             bit_valid,
   output logic             last_bit,
   output logic             done
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] sreg, sreg_n;
   logic             x_n, bv_n, lb_n, done_n;
   logic             accept;

   // Ready while idle, or on the final bit so the next word follows without a gap.
   assign load_ready = (state == IDLE) || (cnt == '0);
   assign accept     = load_valid && load_ready && !flush;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         sreg      <= '0;
         x_out     <= IDLE_LEVEL;
         bit_valid <= 1'b0;
         last_bit  <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         sreg      <= sreg_n;
         x_out     <= x_n;
         bit_valid <= bv_n;
         last_bit  <= lb_n;
         done      <= done_n;
      end
   end

   // Next-state and next-output logic; flush overrides both loading and shifting.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sreg_n  = sreg;
      x_n     = x_out;
      bv_n    = bit_valid;
      lb_n    = last_bit;
      done_n  = 1'b0;

      if (flush) begin
         state_n = IDLE;
         cnt_n   = '0;
         x_n     = IDLE_LEVEL;
         bv_n    = 1'b0;
         lb_n    = 1'b0;
      end else if (accept) begin
         // Accepting while in SHIFT means the current word is on its last bit.
         done_n  = (state == SHIFT);
         state_n = SHIFT;
         sreg_n  = din;
         cnt_n   = CW'(WIDTH - 1);
         x_n     = din[WIDTH-1];
         bv_n    = 1'b1;
         lb_n    = 1'b0;
      end else if (state == SHIFT) begin
         if (cnt != '0) begin
            sreg_n = {sreg[WIDTH-2:0], 1'b0};
            x_n    = sreg[WIDTH-2];
            cnt_n  = cnt - CW'(1);
            lb_n   = (cnt == CW'(1));
         end else begin
            done_n  = 1'b1;
            state_n = IDLE;
            x_n     = IDLE_LEVEL;
            bv_n    = 1'b0;
            lb_n    = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_word_shifter.sv
// Bench for serial_word_shifter: directed scenarios plus random traffic against a
// queue-based model of the serial stream.
module tb_serial_word_shifter;

   localparam int unsigned W = 8;

   logic         clock = 1'b0;
   logic         reset;
   logic [W-1:0] din;
   logic         load_valid, flush;
   logic         load_ready, x_out, bit_valid, last_bit, done;

   int unsigned total  = 0;
   int unsigned passed = 0;

   // Model: bits still to be presented, plus the expected registered outputs.
   bit q[$];
   bit m_x, m_bv, m_lb, m_done;

   serial_word_shifter #(.WIDTH(W), .IDLE_LEVEL(1'b1)) dut (
      .clock      (clock),
      .reset      (reset),
      .din        (din),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .flush      (flush),
      .x_out      (x_out),
      .bit_valid  (bit_valid),
      .last_bit   (last_bit),
      .done       (done)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_x    = 1'b1;
      m_bv   = 1'b0;
      m_lb   = 1'b0;
      m_done = 1'b0;
   endtask

   function automatic bit m_rdy();
      return !m_bv || m_lb;
   endfunction

   // One rising edge of the model with the inputs that were held before it.
   task automatic model_edge(input bit lv, input bit fl, input logic [W-1:0] d);
      bit fin, acc;
      if (fl) begin
         model_reset();
         return;
      end
      fin    = m_bv && m_lb;
      acc    = lv && m_rdy();
      m_done = fin;
      if (acc) begin
         q.delete();
         for (int i = W - 1; i >= 0; i--) q.push_back(d[i]);
         m_x  = q.pop_front();
         m_bv = 1'b1;
         m_lb = (q.size() == 0);
      end else if (m_bv && !m_lb) begin
         m_x  = q.pop_front();
         m_lb = (q.size() == 0);
      end else begin
         m_x  = 1'b1;
         m_bv = 1'b0;
         m_lb = 1'b0;
      end
   endtask

   task automatic check_outputs();
      check("x_out", x_out, m_x);
      check("bit_valid", bit_valid, m_bv);
      check("last_bit", last_bit, m_lb);
      check("done", done, m_done);
   endtask

   // Called just after a falling edge: drive, check ready, clock once, check outputs.
   task automatic step(input bit lv, input bit fl, input logic [W-1:0] d);
      load_valid = lv;
      flush      = fl;
      din        = d;
      #1 check("load_ready", load_ready, m_rdy());
      @(posedge clock);
      model_edge(lv, fl, d);
      @(negedge clock);
      #1 check_outputs();
   endtask

   logic [W-1:0]   a5_obs;
   logic [2*W-1:0] b2b_obs;
   int unsigned    done_cnt, bv_cnt;

   initial begin
      reset      = 1'b0;
      load_valid = 1'b1;
      flush      = 1'b0;
      din        = 8'hA5;
      model_reset();

      // Reset held for 100 ns with a load pending: nothing may start.
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("rst_x_out", x_out, 1'b1);
         check("rst_bit_valid", bit_valid, 1'b0);
         check("rst_done", done, 1'b0);
         check("rst_load_ready", load_ready, 1'b1);
      end
      load_valid = 1'b0;
      reset      = 1'b1;

      // Single word 0xA5.
      step(1'b1, 1'b0, 8'hA5);
      a5_obs[W-1] = x_out;
      for (int k = W - 2; k >= 0; k--) begin
         step(1'b0, 1'b0, W'($urandom));
         a5_obs[k] = x_out;
      end
      check("a5_stream", a5_obs, 8'hA5);
      check("a5_last_bit", last_bit, 1'b1);
      step(1'b0, 1'b0, 8'h00);
      check("a5_done", done, 1'b1);
      check("a5_idle_x", x_out, 1'b1);
      step(1'b0, 1'b0, 8'h00);

      // Back-to-back 0x00 then 0xFF with load_valid held high.
      done_cnt = 0;
      bv_cnt   = 0;
      for (int k = 0; k < 2 * W; k++) begin
         step(1'b1, 1'b0, (k < W) ? 8'h00 : 8'hFF);
         b2b_obs[2*W-1-k] = x_out;
         if (bit_valid) bv_cnt++;
         if (done) done_cnt++;
      end
      step(1'b0, 1'b0, 8'h00);
      if (done) done_cnt++;
      check("b2b_stream", b2b_obs, 16'h00FF);
      check("b2b_valid_cycles", bv_cnt, 2 * W);
      check("b2b_done_pulses", done_cnt, 2);
      step(1'b0, 1'b0, 8'h00);

      // Flush during the 4th bit of 0x3C, then a new load the following cycle.
      step(1'b1, 1'b0, 8'h3C);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h00);
      check("flush_x_out", x_out, 1'b1);
      check("flush_no_done", done, 1'b0);
      step(1'b1, 1'b0, 8'hC3);
      check("flush_reload", bit_valid, 1'b1);
      for (int k = 0; k < W; k++) step(1'b0, 1'b0, 8'h00);

      // Asynchronous reset during the 3rd bit of 0x81.
      step(1'b1, 1'b0, 8'h81);
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      #2 reset = 1'b0;
      #1;
      check("async_x_out", x_out, 1'b1);
      check("async_bit_valid", bit_valid, 1'b0);
      check("async_done", done, 1'b0);
      model_reset();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00);

      // Mid-word load of 0x55 must be ignored.
      step(1'b1, 1'b0, 8'hE7);
      for (int k = 0; k < W + 1; k++) step(k == 3, 1'b0, 8'h55);

      // Random traffic.
      for (int k = 0; k < 400; k++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, W'($urandom));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
